// File: rtl/axi_word_mem_pkg.sv
// Shared types, response codes and index helper for axi_word_mem and its RAM.
// Bundled AXI structs mirror the single-beat subset the obi_2_axi bridge drives.
package axi_word_mem_pkg;

  localparam int unsigned AXI_ID_W   = 4;
  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 32;
  localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    WR_IDLE    = 2'd0,
    WR_WAIT_W  = 2'd1,
    WR_WAIT_AW = 2'd2,
    WR_RESP    = 2'd3
  } wr_state_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_e;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
  } axi_ax_chan_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0] data;
    logic [AXI_STRB_W-1:0] strb;
    logic                  last;
  } axi_w_chan_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [1:0]          resp;
  } axi_b_chan_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } axi_r_chan_t;

  typedef struct packed {
    axi_ax_chan_t aw;
    logic         aw_valid;
    axi_w_chan_t  w;
    logic         w_valid;
    logic         b_ready;
    axi_ax_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
  } mem_axi_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    logic        b_valid;
    axi_b_chan_t b;
    logic        r_valid;
    axi_r_chan_t r;
  } mem_axi_resp_t;

  // Word index of a byte address relative to the base; caller truncates to the array depth.
  function automatic logic [63:0] addr_to_idx(input logic [63:0] addr, input logic [63:0] base,
                                              input int unsigned shift);
    return (addr - base) >> shift;
  endfunction

endpackage

// File: rtl/be_word_ram.sv
// Byte-enable word RAM: one write port, one registered read port.
// A read and a write to the same index in one cycle return the old contents.
module be_word_ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned DATAW = 32,
  localparam int unsigned STRBW = DATAW / 8,
  localparam int unsigned IDXW  = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we,
  input  logic [IDXW-1:0]  widx,
  input  logic [DATAW-1:0] wdata,
  input  logic [STRBW-1:0] wstrb,
  input  logic             re,
  input  logic [IDXW-1:0]  ridx,
  output logic [DATAW-1:0] rdata
);

  logic [DATAW-1:0] mem_r [DEPTH];
  logic [DATAW-1:0] rdata_r;

  // Array storage is deliberately unreset; the read register holds until the next read.
  always_ff @(posedge clk_i) begin
    if (re) begin
      rdata_r <= mem_r[ridx];
    end
    for (int i = 0; i < int'(STRBW); i++) begin
      if (we && wstrb[i]) begin
        mem_r[widx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/axi_word_mem.sv
// Single-beat AXI4 slave backed by a byte-writable word array, one transaction per direction.
// Optional address decode (DECERR outside the window) via AXI_WORD_MEM_RANGE_CHECK_EN.
module axi_word_mem
  import axi_word_mem_pkg::*;
#(
  parameter int unsigned      MEM_DEPTH = 256,
  parameter int unsigned      ADDRW     = 32,
  parameter int unsigned      DATAW     = 32,
  parameter int unsigned      STRBW     = DATAW / 8,
  parameter logic [ADDRW-1:0] BASE_ADDR = 32'h0,
  parameter type              axi_req_t  = axi_word_mem_pkg::mem_axi_req_t,
  parameter type              axi_resp_t = axi_word_mem_pkg::mem_axi_resp_t
) (
  input  logic      clk_i,
  input  logic      arst_ni,
  input  axi_req_t  axi_req_i,
  output axi_resp_t axi_resp_o
);

  localparam int unsigned IDXW     = $clog2(MEM_DEPTH);
  localparam int unsigned SHIFT    = $clog2(STRBW);
  localparam logic [63:0] BASE_EXT = 64'(BASE_ADDR);

  wr_state_e wr_state_r, wr_state_n;
  rd_state_e rd_state_r, rd_state_n;

  logic aw_ready_r, w_ready_r, ar_ready_r, b_valid_r, r_valid_r, r_last_r, r_zero_r;
  logic [AXI_ID_W-1:0] aw_id_r, b_id_r, r_id_r;
  logic [ADDRW-1:0]    aw_addr_r;
  logic [7:0]          aw_len_r;
  logic [DATAW-1:0]    w_data_r;
  logic [STRBW-1:0]    w_strb_r;
  logic                w_last_r;
  logic [1:0]          b_resp_r, r_resp_r;

  logic aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s, commit_s, we_s;
  logic [AXI_ID_W-1:0] c_id_s;
  logic [ADDRW-1:0]    c_addr_s;
  logic [7:0]          c_len_s;
  logic [DATAW-1:0]    c_data_s, ram_rdata_s;
  logic [STRBW-1:0]    c_strb_s;
  logic                c_last_s, w_oor_s, r_oor_s;
  logic [1:0]          c_resp_s, ar_resp_s;
  logic [63:0]         w_idx_full_s, r_idx_full_s;
  logic                unused_s;

  function automatic logic [1:0] calc_resp(input logic oor, input logic [7:0] len, input logic last);
    logic [1:0] resp;
    if (oor) begin
      resp = RESP_DECERR;
    end else if ((len != 8'd0) || !last) begin
      resp = RESP_SLVERR;
    end else begin
      resp = RESP_OKAY;
    end
    return resp;
  endfunction

  assign aw_hs_s = axi_req_i.aw_valid && aw_ready_r;
  assign w_hs_s  = axi_req_i.w_valid && w_ready_r;
  assign b_hs_s  = b_valid_r && axi_req_i.b_ready;
  assign ar_hs_s = axi_req_i.ar_valid && ar_ready_r;
  assign r_hs_s  = r_valid_r && axi_req_i.r_ready;

  // Commit uses whichever half of the write arrived earlier from its latch.
  always_comb begin
    if (wr_state_r == WR_WAIT_W) begin
      c_id_s   = aw_id_r;
      c_addr_s = aw_addr_r;
      c_len_s  = aw_len_r;
    end else begin
      c_id_s   = axi_req_i.aw.id;
      c_addr_s = axi_req_i.aw.addr;
      c_len_s  = axi_req_i.aw.len;
    end
    if (wr_state_r == WR_WAIT_AW) begin
      c_data_s = w_data_r;
      c_strb_s = w_strb_r;
      c_last_s = w_last_r;
    end else begin
      c_data_s = axi_req_i.w.data;
      c_strb_s = axi_req_i.w.strb;
      c_last_s = axi_req_i.w.last;
    end
  end

`ifdef AXI_WORD_MEM_RANGE_CHECK_EN
  localparam logic [ADDRW:0] SPAN = (ADDRW + 1)'(MEM_DEPTH * STRBW);

  function automatic logic in_window(input logic [ADDRW-1:0] addr);
    logic [ADDRW-1:0] off;
    off = addr - BASE_ADDR;
    return (addr >= BASE_ADDR) && ({1'b0, off} < SPAN);
  endfunction

  assign w_oor_s = !in_window(c_addr_s);
  assign r_oor_s = !in_window(axi_req_i.ar.addr);
`else
  assign w_oor_s = 1'b0;
  assign r_oor_s = 1'b0;
`endif

  assign c_resp_s     = calc_resp(w_oor_s, c_len_s, c_last_s);
  assign ar_resp_s    = calc_resp(r_oor_s, axi_req_i.ar.len, 1'b1);
  assign we_s         = commit_s && (c_resp_s == RESP_OKAY);
  assign w_idx_full_s = addr_to_idx(64'(c_addr_s), BASE_EXT, SHIFT);
  assign r_idx_full_s = addr_to_idx(64'(axi_req_i.ar.addr), BASE_EXT, SHIFT);

  // Write FSM next state and commit strobe.
  always_comb begin
    wr_state_n = wr_state_r;
    commit_s   = 1'b0;
    case (wr_state_r)
      WR_IDLE: begin
        if (aw_hs_s && w_hs_s) begin
          commit_s   = 1'b1;
          wr_state_n = WR_RESP;
        end else if (aw_hs_s) begin
          wr_state_n = WR_WAIT_W;
        end else if (w_hs_s) begin
          wr_state_n = WR_WAIT_AW;
        end else begin
          wr_state_n = WR_IDLE;
        end
      end
      WR_WAIT_W: begin
        if (w_hs_s) begin
          commit_s   = 1'b1;
          wr_state_n = WR_RESP;
        end else begin
          wr_state_n = WR_WAIT_W;
        end
      end
      WR_WAIT_AW: begin
        if (aw_hs_s) begin
          commit_s   = 1'b1;
          wr_state_n = WR_RESP;
        end else begin
          wr_state_n = WR_WAIT_AW;
        end
      end
      WR_RESP: begin
        if (b_hs_s) begin
          wr_state_n = WR_IDLE;
        end else begin
          wr_state_n = WR_RESP;
        end
      end
      default: wr_state_n = WR_IDLE;
    endcase
  end

  // Write state, channel latches, registered readys and the B channel.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      wr_state_r <= WR_IDLE;
      aw_ready_r <= 1'b0;
      w_ready_r  <= 1'b0;
      b_valid_r  <= 1'b0;
      b_id_r     <= {AXI_ID_W{1'b0}};
      b_resp_r   <= RESP_OKAY;
      aw_id_r    <= {AXI_ID_W{1'b0}};
      aw_addr_r  <= {ADDRW{1'b0}};
      aw_len_r   <= 8'd0;
      w_data_r   <= {DATAW{1'b0}};
      w_strb_r   <= {STRBW{1'b0}};
      w_last_r   <= 1'b0;
    end else begin
      wr_state_r <= wr_state_n;
      aw_ready_r <= (wr_state_n == WR_IDLE) || (wr_state_n == WR_WAIT_AW);
      w_ready_r  <= (wr_state_n == WR_IDLE) || (wr_state_n == WR_WAIT_W);
      b_valid_r  <= (wr_state_n == WR_RESP);
      if (aw_hs_s) begin
        aw_id_r   <= axi_req_i.aw.id;
        aw_addr_r <= axi_req_i.aw.addr;
        aw_len_r  <= axi_req_i.aw.len;
      end
      if (w_hs_s) begin
        w_data_r <= axi_req_i.w.data;
        w_strb_r <= axi_req_i.w.strb;
        w_last_r <= axi_req_i.w.last;
      end
      if (commit_s) begin
        b_id_r   <= c_id_s;
        b_resp_r <= c_resp_s;
      end
    end
  end

  // Read FSM next state.
  always_comb begin
    rd_state_n = rd_state_r;
    case (rd_state_r)
      RD_IDLE: begin
        if (ar_hs_s) begin
          rd_state_n = RD_RESP;
        end else begin
          rd_state_n = RD_IDLE;
        end
      end
      RD_RESP: begin
        if (r_hs_s) begin
          rd_state_n = RD_IDLE;
        end else begin
          rd_state_n = RD_RESP;
        end
      end
      default: rd_state_n = RD_IDLE;
    endcase
  end

  // Read state and R channel; r_zero_r masks the RAM word on error responses.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      rd_state_r <= RD_IDLE;
      ar_ready_r <= 1'b0;
      r_valid_r  <= 1'b0;
      r_id_r     <= {AXI_ID_W{1'b0}};
      r_resp_r   <= RESP_OKAY;
      r_last_r   <= 1'b0;
      r_zero_r   <= 1'b1;
    end else begin
      rd_state_r <= rd_state_n;
      ar_ready_r <= (rd_state_n == RD_IDLE);
      r_valid_r  <= (rd_state_n == RD_RESP);
      if (ar_hs_s) begin
        r_id_r   <= axi_req_i.ar.id;
        r_resp_r <= ar_resp_s;
        r_last_r <= 1'b1;
        r_zero_r <= (ar_resp_s != RESP_OKAY);
      end
    end
  end

  be_word_ram #(
    .DEPTH(MEM_DEPTH),
    .DATAW(DATAW)
  ) u_ram (
    .clk_i(clk_i),
    .we   (we_s),
    .widx (w_idx_full_s[IDXW-1:0]),
    .wdata(c_data_s),
    .wstrb(c_strb_s),
    .re   (ar_hs_s),
    .ridx (r_idx_full_s[IDXW-1:0]),
    .rdata(ram_rdata_s)
  );

  assign axi_resp_o.aw_ready = aw_ready_r;
  assign axi_resp_o.w_ready  = w_ready_r;
  assign axi_resp_o.ar_ready = ar_ready_r;
  assign axi_resp_o.b_valid  = b_valid_r;
  assign axi_resp_o.b.id     = b_id_r;
  assign axi_resp_o.b.resp   = b_resp_r;
  assign axi_resp_o.r_valid  = r_valid_r;
  assign axi_resp_o.r.id     = r_id_r;
  assign axi_resp_o.r.data   = r_zero_r ? {DATAW{1'b0}} : ram_rdata_s;
  assign axi_resp_o.r.resp   = r_resp_r;
  assign axi_resp_o.r.last   = r_last_r;

  assign unused_s = ^{axi_req_i.aw.size, axi_req_i.aw.burst, axi_req_i.aw.lock,
                      axi_req_i.aw.cache, axi_req_i.aw.prot, axi_req_i.ar.size,
                      axi_req_i.ar.burst, axi_req_i.ar.lock, axi_req_i.ar.cache,
                      axi_req_i.ar.prot, w_idx_full_s[63:IDXW], r_idx_full_s[63:IDXW]};

endmodule

// File: tb/tb_axi_word_mem.sv
// Directed self-checking bench for axi_word_mem (default build or AXI_WORD_MEM_RANGE_CHECK_EN).
module tb_axi_word_mem;
  import axi_word_mem_pkg::*;

  logic          clk_i = 1'b0;
  logic          arst_ni;
  mem_axi_req_t  axi_req;
  mem_axi_resp_t axi_resp;
  int            n_tests = 0;
  int            n_fail  = 0;

  logic [3:0]  bid, rid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        rlast;

  always #5 clk_i = ~clk_i;

  axi_word_mem dut (
    .clk_i     (clk_i),
    .arst_ni   (arst_ni),
    .axi_req_i (axi_req),
    .axi_resp_o(axi_resp)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [3:0] id, input logic [31:0] data,
                    input logic [3:0] strb, input logic [7:0] len, input logic last,
                    output logic [3:0] o_id, output logic [1:0] o_resp);
    logic aw_go, w_go;
    int   n;
    @(negedge clk_i);
    axi_req.aw      = '0;
    axi_req.aw.addr = addr;
    axi_req.aw.id   = id;
    axi_req.aw.len  = len;
    axi_req.w.data  = data;
    axi_req.w.strb  = strb;
    axi_req.w.last  = last;
    axi_req.aw_valid = 1'b1;
    axi_req.w_valid  = 1'b1;
    n = 0;
    while ((axi_req.aw_valid || axi_req.w_valid) && n < 20) begin
      aw_go = axi_req.aw_valid && axi_resp.aw_ready;
      w_go  = axi_req.w_valid && axi_resp.w_ready;
      @(negedge clk_i);
      if (aw_go) axi_req.aw_valid = 1'b0;
      if (w_go) axi_req.w_valid = 1'b0;
      n++;
    end
    check("wr_accept", 64'(n < 20), 64'd1);
    check("b_latency", 64'(axi_resp.b_valid), 64'd1);
    o_id   = axi_resp.b.id;
    o_resp = axi_resp.b.resp;
    axi_req.aw_valid = 1'b0;
    axi_req.w_valid  = 1'b0;
    axi_req.b_ready  = 1'b1;
    @(negedge clk_i);
    axi_req.b_ready = 1'b0;
    check("b_release", 64'(axi_resp.b_valid), 64'd0);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                    output logic [31:0] o_data, output logic [3:0] o_id,
                    output logic [1:0] o_resp, output logic o_last);
    int n;
    @(negedge clk_i);
    axi_req.ar      = '0;
    axi_req.ar.addr = addr;
    axi_req.ar.id   = id;
    axi_req.ar.len  = len;
    axi_req.ar_valid = 1'b1;
    n = 0;
    while (!axi_resp.ar_ready && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    @(negedge clk_i);
    axi_req.ar_valid = 1'b0;
    check("rd_accept", 64'(n < 20), 64'd1);
    check("r_latency", 64'(axi_resp.r_valid), 64'd1);
    o_data = axi_resp.r.data;
    o_id   = axi_resp.r.id;
    o_resp = axi_resp.r.resp;
    o_last = axi_resp.r.last;
    axi_req.r_ready = 1'b1;
    @(negedge clk_i);
    axi_req.r_ready = 1'b0;
    check("r_release", 64'(axi_resp.r_valid), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    axi_req = '0;
    arst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    check("rst_aw_ready", 64'(axi_resp.aw_ready), 64'd0);
    check("rst_w_ready", 64'(axi_resp.w_ready), 64'd0);
    check("rst_ar_ready", 64'(axi_resp.ar_ready), 64'd0);
    check("rst_b_valid", 64'(axi_resp.b_valid), 64'd0);
    check("rst_r_valid", 64'(axi_resp.r_valid), 64'd0);
    check("rst_r_data", 64'(axi_resp.r.data), 64'd0);
    arst_ni = 1'b1;
    @(negedge clk_i);
    check("post_rst_readys", 64'({axi_resp.aw_ready, axi_resp.w_ready, axi_resp.ar_ready}), 64'd7);

    wr(32'h0C, 4'd5, 32'hDEADBEEF, 4'hF, 8'd0, 1'b1, bid, bresp);
    check("wr1_bid", 64'(bid), 64'd5);
    check("wr1_bresp", 64'(bresp), 64'(RESP_OKAY));
    rd(32'h0C, 4'd2, 8'd0, rdata, rid, rresp, rlast);
    check("rd1_data", 64'(rdata), 64'hDEADBEEF);
    check("rd1_id", 64'(rid), 64'd2);
    check("rd1_last", 64'(rlast), 64'd1);
    check("rd1_resp", 64'(rresp), 64'(RESP_OKAY));

    wr(32'h0C, 4'd1, 32'h11223344, 4'b0101, 8'd0, 1'b1, bid, bresp);
    rd(32'h0C, 4'd3, 8'd0, rdata, rid, rresp, rlast);
    check("partial_strb", 64'(rdata), 64'hDE22BE44);

    // W first, AW handshake three edges later, then B back-pressure.
    @(negedge clk_i);
    axi_req.w.data  = 32'hCAFEF00D;
    axi_req.w.strb  = 4'hF;
    axi_req.w.last  = 1'b1;
    axi_req.w_valid = 1'b1;
    check("dec_w_ready", 64'(axi_resp.w_ready), 64'd1);
    @(negedge clk_i);
    axi_req.w_valid = 1'b0;
    check("dec_w_ready_low", 64'(axi_resp.w_ready), 64'd0);
    check("dec_aw_ready_high", 64'(axi_resp.aw_ready), 64'd1);
    @(negedge clk_i);
    @(negedge clk_i);
    axi_req.aw      = '0;
    axi_req.aw.addr = 32'h10;
    axi_req.aw.id   = 4'd7;
    axi_req.aw_valid = 1'b1;
    check("dec_b_early", 64'(axi_resp.b_valid), 64'd0);
    @(negedge clk_i);
    axi_req.aw_valid = 1'b0;
    check("dec_b_valid", 64'(axi_resp.b_valid), 64'd1);
    check("dec_b_id", 64'(axi_resp.b.id), 64'd7);
    check("dec_b_resp", 64'(axi_resp.b.resp), 64'(RESP_OKAY));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("stall_b_valid", 64'(axi_resp.b_valid), 64'd1);
      check("stall_b_id", 64'(axi_resp.b.id), 64'd7);
      check("stall_aw_ready", 64'(axi_resp.aw_ready), 64'd0);
    end
    axi_req.b_ready = 1'b1;
    @(negedge clk_i);
    axi_req.b_ready = 1'b0;
    check("dec_b_done", 64'(axi_resp.b_valid), 64'd0);
    check("dec_readys_back", 64'({axi_resp.aw_ready, axi_resp.w_ready}), 64'd3);
    rd(32'h10, 4'd4, 8'd0, rdata, rid, rresp, rlast);
    check("dec_readback", 64'(rdata), 64'hCAFEF00D);

    rd(32'h0C, 4'd9, 8'd3, rdata, rid, rresp, rlast);
    check("arlen_resp", 64'(rresp), 64'(RESP_SLVERR));
    check("arlen_data", 64'(rdata), 64'd0);
    check("arlen_last", 64'(rlast), 64'd1);
    check("arlen_id", 64'(rid), 64'd9);

    wr(32'h0C, 4'd6, 32'h0, 4'hF, 8'd1, 1'b1, bid, bresp);
    check("awlen_resp", 64'(bresp), 64'(RESP_SLVERR));
    wr(32'h0C, 4'd6, 32'h0, 4'hF, 8'd0, 1'b0, bid, bresp);
    check("wlast_resp", 64'(bresp), 64'(RESP_SLVERR));
    rd(32'h0C, 4'd0, 8'd0, rdata, rid, rresp, rlast);
    check("err_no_update", 64'(rdata), 64'hDE22BE44);

    // Read and write commit to the same word on one edge.
    @(negedge clk_i);
    axi_req.aw      = '0;
    axi_req.aw.addr = 32'h0C;
    axi_req.aw.id   = 4'd3;
    axi_req.w.data  = 32'h55667788;
    axi_req.w.strb  = 4'hF;
    axi_req.w.last  = 1'b1;
    axi_req.ar      = '0;
    axi_req.ar.addr = 32'h0C;
    axi_req.ar.id   = 4'd4;
    axi_req.aw_valid = 1'b1;
    axi_req.w_valid  = 1'b1;
    axi_req.ar_valid = 1'b1;
    check("rbw_readys", 64'({axi_resp.aw_ready, axi_resp.w_ready, axi_resp.ar_ready}), 64'd7);
    @(negedge clk_i);
    axi_req.aw_valid = 1'b0;
    axi_req.w_valid  = 1'b0;
    axi_req.ar_valid = 1'b0;
    check("rbw_r_valid", 64'(axi_resp.r_valid), 64'd1);
    check("rbw_old_data", 64'(axi_resp.r.data), 64'hDE22BE44);
    check("rbw_b_valid", 64'(axi_resp.b_valid), 64'd1);
    axi_req.b_ready = 1'b1;
    axi_req.r_ready = 1'b1;
    @(negedge clk_i);
    axi_req.b_ready = 1'b0;
    axi_req.r_ready = 1'b0;
    rd(32'h0C, 4'd1, 8'd0, rdata, rid, rresp, rlast);
    check("rbw_new_data", 64'(rdata), 64'h55667788);

    wr(32'h00, 4'd0, 32'h0BADC0DE, 4'hF, 8'd0, 1'b1, bid, bresp);
    rd(32'h400, 4'd8, 8'd0, rdata, rid, rresp, rlast);
`ifdef AXI_WORD_MEM_RANGE_CHECK_EN
    check("range_resp", 64'(rresp), 64'(RESP_DECERR));
    check("range_data", 64'(rdata), 64'd0);
`else
    check("range_resp", 64'(rresp), 64'(RESP_OKAY));
    check("range_data", 64'(rdata), 64'h0BADC0DE);
`endif

    // Reset while an R beat is pending drops it; memory survives.
    @(negedge clk_i);
    axi_req.ar      = '0;
    axi_req.ar.addr = 32'h00;
    axi_req.ar_valid = 1'b1;
    @(negedge clk_i);
    axi_req.ar_valid = 1'b0;
    check("mid_r_valid", 64'(axi_resp.r_valid), 64'd1);
    arst_ni = 1'b0;
    #1;
    check("mid_rst_r_valid", 64'(axi_resp.r_valid), 64'd0);
    check("mid_rst_ar_ready", 64'(axi_resp.ar_ready), 64'd0);
    @(negedge clk_i);
    arst_ni = 1'b1;
    @(negedge clk_i);
    check("mid_rst_ready_back", 64'(axi_resp.ar_ready), 64'd1);
    rd(32'h00, 4'd2, 8'd0, rdata, rid, rresp, rlast);
    check("mid_rst_mem_kept", 64'(rdata), 64'h0BADC0DE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_word_mem.md
Name: axi_word_mem

Overview:
- Single-clock AXI4 slave on the AXI side of obi_2_axi.
- Consumes the single-beat AXI requests the bridge produces and backs them with a byte-writable word array.
- Used as scratch/peripheral memory behind the bridge, and as the bridge's reference target in system benches.
- Independent read and write paths; one outstanding transaction per direction.

Parameters:
- MEM_DEPTH, 256, number of data words (power of two, >=2).
- ADDRW, 32, AXI address width.
- DATAW, 32, AXI data width (32 or 64).
- STRBW, DATAW/8, write-strobe width.
- BASE_ADDR, 32'h0, byte address mapped to word 0.
- axi_req_t, logic, AXI request struct type (from AXI_TYPEDEF_ALL).
- axi_resp_t, logic, AXI response struct type.

Ports:
- clk_i  in  1  clock (AXI domain).
- arst_ni  in  1  asynchronous active-low reset.
- axi_req_i  in  axi_req_t  AW/W/AR channels plus b_ready, r_ready.
- axi_resp_o  out  axi_resp_t  aw/w/ar_ready plus B and R channels.

Behaviour:
- Reset values: all readys 0, b_valid 0, r_valid 0, b.resp 0, r.data 0, r.resp 0, r.last 0, IDs 0.
  - Memory contents are not reset.
  - Readys rise on the first clk_i edge after reset release.
- Index computation: idx = (addr - BASE_ADDR) >> log2(STRBW), truncated to log2(MEM_DEPTH) bits.
- Write FSM, states WR_IDLE, WR_WAIT_W, WR_WAIT_AW, WR_RESP:
  - WR_IDLE: aw_ready=1, w_ready=1.
    - AW and W in the same cycle -> commit, go to WR_RESP.
    - AW only -> latch AW, go to WR_WAIT_W, aw_ready=0.
    - W only -> latch W, go to WR_WAIT_AW, w_ready=0.
  - WR_WAIT_W / WR_WAIT_AW: only the missing channel is ready. On its handshake -> commit, go to WR_RESP.
  - Commit: each byte lane i with strb[i]=1 is written in the commit cycle. b_valid rises the next cycle with b.id=aw.id.
  - WR_RESP: hold b_valid/b.id/b.resp until b_ready. Then return to WR_IDLE; readys reassert the following cycle.
  - Write response: aw.len!=0 or w.last=0 -> b.resp=SLVERR, no array update; otherwise OKAY.
- Read FSM, states RD_IDLE, RD_RESP:
  - RD_IDLE: ar_ready=1. On handshake, the array is read that edge, then r_valid=1, r.data, r.id=ar.id, r.last=1 next cycle.
  - RD_RESP: hold all R fields stable until r_ready. Then return to RD_IDLE; ar_ready=1 the next cycle.
  - ar.len!=0 -> r.resp=SLVERR, r.data=0, single beat with last=1; otherwise OKAY.
- Latency: AR handshake to r_valid = 1 cycle. Final AW/W handshake to b_valid = 1 cycle.
- Simultaneous AR accept and write commit to the same idx: read returns the pre-write data (read-before-write).
- Bursts, size, cache and prot are ignored except for the len check.
- Reset mid-transaction: both FSMs return to IDLE immediately and any pending B/R is dropped. A committed write stays committed.

Optional Feature:
- Macro: AXI_WORD_MEM_RANGE_CHECK_EN.
- Defined: an address outside [BASE_ADDR, BASE_ADDR + MEM_DEPTH*STRBW) returns DECERR (2'b11).
  - Writes: no array update.
  - Reads: r.data=0.
  - DECERR takes priority over SLVERR.
- Undefined: no decode; the index wraps modulo MEM_DEPTH and every in-len access returns OKAY.

Decomposition:
- Package axi_word_mem_pkg holds:
  - wr_state_e and rd_state_e enums.
  - Response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - Function addr_to_idx.
- One sub-module, be_word_ram:
  - Parameters DEPTH and DATAW; one write port with byte enables; one synchronous read port.
  - Read-before-write on the same index.

Test Plan:
- Reset check: arst_ni low -> all readys, b_valid and r_valid are 0. One edge after release -> aw_ready=w_ready=ar_ready=1.
- Write then read, idx 3:
  - AW addr 32'h0C, id 5 with W data 32'hDEADBEEF, strb 4'hF, same cycle -> B OKAY id 5 one cycle later.
  - AR 32'h0C id 2 -> r.data 32'hDEADBEEF, id 2, last 1.
- Partial strobe: write 32'h11223344, strb 4'b0101 onto 32'hDEADBEEF -> read gives 32'hDE22BE44.
- Decoupled channels:
  - W first, AW three cycles later -> b_valid exactly one cycle after the AW handshake.
  - b_ready held low for 5 cycles -> B stable, aw_ready stays 0.
- Error: AR with len=3 -> single beat SLVERR, data 0. AW len=1 -> SLVERR and memory unchanged.
- Range check (macro defined, MEM_DEPTH 256): read at 32'h400 -> DECERR. Same test undefined -> returns the word at idx 0.
